// File: rtl/fetch_skid_buffer.sv
// Two-entry skid buffer between instruction fetch and decode, with flush/drain handling.
// Optional sticky overflow flag enabled by defining FETCH_SKID_OVERFLOW_EN.
module fetch_skid_buffer #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FETCH_stall,
  input  logic        FETCH_flush,
  input  logic        IMEM_valid,
  input  logic [31:0] IMEM_instr,
  input  logic [31:0] IMEM_pc,
  output logic        IMEM_ready,
  output logic        DEC_valid,
  output logic [31:0] DEC_instr,
  output logic [31:0] DEC_pc,
  output logic        overflow
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [31:0] w_out_instr_nxt;
  logic [31:0] w_out_pc_nxt;
  logic [31:0] w_skid_instr_nxt;
  logic [31:0] w_skid_pc_nxt;
  logic        w_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_out_instr  <= NOP_INSTR;
      r_out_pc     <= 32'd0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_out_instr  <= w_out_instr_nxt;
      r_out_pc     <= w_out_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_out_instr_nxt  = r_out_instr;
    w_out_pc_nxt     = r_out_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    if (FETCH_flush) begin
      // Flush wins over everything; the response already in flight is dropped in DRAIN.
      w_state_nxt      = DRAIN;
      w_out_instr_nxt  = NOP_INSTR;
      w_out_pc_nxt     = 32'd0;
      w_skid_instr_nxt = NOP_INSTR;
      w_skid_pc_nxt    = 32'd0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (IMEM_valid) begin
            w_out_instr_nxt = IMEM_instr;
            w_out_pc_nxt    = IMEM_pc;
            w_state_nxt     = ONE;
          end
        end
        ONE: begin
          if (!FETCH_stall) begin
            if (IMEM_valid) begin
              w_out_instr_nxt = IMEM_instr;
              w_out_pc_nxt    = IMEM_pc;
              w_state_nxt     = ONE;
            end else begin
              w_state_nxt = EMPTY;
            end
          end else if (IMEM_valid) begin
            w_skid_instr_nxt = IMEM_instr;
            w_skid_pc_nxt    = IMEM_pc;
            w_state_nxt      = FULL;
          end
        end
        FULL: begin
          // A response arriving here has nowhere to go and is dropped.
          if (!FETCH_stall) begin
            w_out_instr_nxt = r_skid_instr;
            w_out_pc_nxt    = r_skid_pc;
            w_state_nxt     = ONE;
          end
        end
        DRAIN: begin
          w_state_nxt = EMPTY;
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  assign w_out_valid = (r_state == ONE) || (r_state == FULL);
  assign IMEM_ready  = ((r_state == EMPTY) || (r_state == ONE)) && !FETCH_flush;
  assign DEC_valid   = w_out_valid;
  assign DEC_instr   = w_out_valid ? r_out_instr : NOP_INSTR;
  assign DEC_pc      = w_out_valid ? r_out_pc : 32'd0;

`ifdef FETCH_SKID_OVERFLOW_EN
  logic r_overflow;
  logic w_ovf_evt;

  assign w_ovf_evt = (r_state == FULL) && IMEM_valid && !FETCH_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_evt) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_skid_buffer.sv
// Bench for fetch_skid_buffer: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the buffer.
module tb_fetch_skid_buffer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        FETCH_stall;
  logic        FETCH_flush;
  logic        IMEM_valid;
  logic [31:0] IMEM_instr;
  logic [31:0] IMEM_pc;
  logic        IMEM_ready;
  logic        DEC_valid;
  logic [31:0] DEC_instr;
  logic [31:0] DEC_pc;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  logic [63:0] m_q[$];
  bit          m_drain = 0;
  bit          m_ovf = 0;

  fetch_skid_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .FETCH_stall (FETCH_stall),
    .FETCH_flush (FETCH_flush),
    .IMEM_valid  (IMEM_valid),
    .IMEM_instr  (IMEM_instr),
    .IMEM_pc     (IMEM_pc),
    .IMEM_ready  (IMEM_ready),
    .DEC_valid   (DEC_valid),
    .DEC_instr   (DEC_instr),
    .DEC_pc      (DEC_pc),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ovf_exp();
`ifdef FETCH_SKID_OVERFLOW_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Model: a FIFO of at most two entries; the head is what decode sees.
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_drain = 0;
      m_ovf   = 0;
    end else if (FETCH_flush) begin
      m_q.delete();
      m_drain = 1;
    end else if (m_drain) begin
      m_drain = 0;
    end else begin
      int n;
      n = m_q.size();
      if (!FETCH_stall && n > 0) void'(m_q.pop_front());
      if (IMEM_valid) begin
        if (n < 2) m_q.push_back({IMEM_pc, IMEM_instr});
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_dec_valid", {31'd0, DEC_valid}, {31'd0, m_q.size() > 0});
      chk("m_dec_instr", DEC_instr, (m_q.size() > 0) ? m_q[0][31:0] : NOP);
      chk("m_dec_pc", DEC_pc, (m_q.size() > 0) ? m_q[0][63:32] : 32'd0);
      chk("m_imem_ready", {31'd0, IMEM_ready},
          {31'd0, !m_drain && (m_q.size() < 2) && !FETCH_flush});
      chk("m_overflow", {31'd0, overflow}, {31'd0, ovf_exp()});
    end
  end

  // Drives one cycle of inputs, lets the edge happen, returns just after it.
  task automatic cyc(input logic r, input logic s, input logic f, input logic v,
                     input logic [31:0] pc);
    rst         = r;
    FETCH_stall = s;
    FETCH_flush = f;
    IMEM_valid  = v;
    IMEM_pc     = pc;
    IMEM_instr  = pc ^ 32'hC0DE0000;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] pc,
                         input logic rdy);
    chk({name, "_valid"}, {31'd0, DEC_valid}, {31'd0, v});
    chk({name, "_pc"}, DEC_pc, v ? pc : 32'd0);
    chk({name, "_instr"}, DEC_instr, v ? (pc ^ 32'hC0DE0000) : NOP);
    chk({name, "_ready"}, {31'd0, IMEM_ready}, {31'd0, rdy});
  endtask

  initial begin
    rst = 1'b1; FETCH_stall = 0; FETCH_flush = 0; IMEM_valid = 0;
    IMEM_pc = 0; IMEM_instr = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 32'h99);
    chk_en = 1;
    chk_out("reset", 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk_out("post_reset", 0, 0, 1);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);

    // streaming
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 32'(i * 4));
      chk_out("stream", 1, 32'(i * 4), 1);
    end
    cyc(0, 0, 0, 0, 0);
    chk_out("stream_end", 0, 0, 1);

    // skid
    cyc(0, 0, 0, 1, 32'h40);
    chk_out("skid_one", 1, 32'h40, 1);
    cyc(0, 1, 0, 1, 32'h10);
    chk_out("skid_full", 1, 32'h40, 0);
    cyc(0, 1, 0, 0, 0);
    chk_out("skid_hold1", 1, 32'h40, 0);
    cyc(0, 1, 0, 0, 0);
    chk_out("skid_hold2", 1, 32'h40, 0);
    cyc(0, 0, 0, 0, 0);
    chk_out("skid_release", 1, 32'h10, 1);

    // flush from FULL, wrong-path response in the following cycle
    cyc(0, 1, 0, 1, 32'h50);
    chk_out("flush_full", 1, 32'h10, 0);
    cyc(0, 0, 1, 0, 0);
    chk_out("flush_drain", 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h20);
    chk_out("flush_drop", 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk_out("flush_empty", 0, 0, 1);

    // flush, stall and valid together
    cyc(0, 0, 0, 1, 32'h60);
    chk_out("simul_one", 1, 32'h60, 1);
    cyc(0, 1, 1, 1, 32'h64);
    chk_out("simul_drain", 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk_out("simul_empty", 0, 0, 1);

    // overflow
    cyc(0, 0, 0, 1, 32'h70);
    cyc(0, 1, 0, 1, 32'h74);
    chk("ovf_before", {31'd0, overflow}, 32'd0);
    cyc(0, 1, 0, 1, 32'h78);
    chk_out("ovf_hold", 1, 32'h70, 0);
`ifdef FETCH_SKID_OVERFLOW_EN
    chk("ovf_set", {31'd0, overflow}, 32'd1);
`else
    chk("ovf_set", {31'd0, overflow}, 32'd0);
`endif
    cyc(0, 0, 0, 0, 0);
    chk_out("ovf_drain_skid", 1, 32'h74, 1);
    cyc(0, 0, 0, 0, 0);
    chk_out("ovf_empty", 0, 0, 1);

    // reset in FULL with flush active
    cyc(0, 0, 0, 1, 32'h80);
    cyc(0, 1, 0, 1, 32'h84);
    chk_out("rst_full", 1, 32'h80, 0);
    cyc(1, 1, 1, 1, 32'h88);
    chk_out("rst_apply", 0, 0, 0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk_out("rst_after", 0, 0, 1);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 2) != 0),
          $urandom());
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_skid_buffer.md
FETCH_SKID_BUFFER -- requirements
Module: fetch_skid_buffer

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction word presented on DEC_instr whenever DEC_valid is 0.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port FETCH_stall, input, 1, from the hazard unit: decode does not consume this cycle.
REQ-005 SHALL have port FETCH_flush, input, 1, from the hazard unit (BRA|JMP): all buffered fetch data is wrong-path.
REQ-006 SHALL have port IMEM_valid, input, 1, instruction memory response valid, exactly 1 cycle after the request.
REQ-007 SHALL have port IMEM_instr, input, 32, response instruction word.
REQ-008 SHALL have port IMEM_pc, input, 32, PC of the response.
REQ-009 SHALL have port IMEM_ready, output, 1, the fetch unit may issue a request this cycle.
REQ-010 SHALL have port DEC_valid, output, 1, DEC_instr/DEC_pc hold a valid instruction for decode.
REQ-011 SHALL have port DEC_instr, output, 32, instruction to decode.
REQ-012 SHALL have port DEC_pc, output, 32, PC to decode.
REQ-013 SHALL have port overflow, output, 1, sticky error flag.

Function
REQ-014 SHALL implement four states: EMPTY (no valid entry), ONE (output register valid), FULL (output and skid registers valid), DRAIN (discarding the in-flight wrong-path response).
REQ-015 SHALL drive IMEM_ready = 1 only in EMPTY or ONE with FETCH_flush = 0, combinationally.
REQ-016 SHALL, in EMPTY or ONE with no stall, load IMEM_* into the output register: ONE if IMEM_valid, else EMPTY.
REQ-017 SHALL, in EMPTY with stall and IMEM_valid, load the output register and go to ONE.
REQ-018 SHALL, in ONE with stall and IMEM_valid, capture IMEM_* into the skid register and go to FULL; the output register holds.
REQ-019 SHALL, in ONE or FULL with stall and no IMEM_valid, hold all registers and state.
REQ-020 SHALL, in FULL with no stall, move the skid register into the output register and go to ONE in one cycle.
REQ-021 SHALL treat IMEM_valid = 1 in FULL as an overflow: drop the data and keep state.
REQ-022 SHALL give FETCH_flush priority over stall and IMEM_valid: clear both entries, drop IMEM_valid that cycle, and enter DRAIN.
REQ-023 SHALL, in DRAIN, drop IMEM_valid and go to EMPTY next cycle; FETCH_flush in DRAIN keeps DRAIN.
REQ-024 SHALL drive DEC_instr = NOP_INSTR and DEC_pc = 0 whenever DEC_valid = 0.
REQ-025 SHALL have 1-cycle latency from an accepted IMEM_valid to DEC_valid in EMPTY/ONE.
REQ-026 SHALL preserve program order: output register before skid register; no instruction duplicated or lost except on flush, drain or overflow.

Reset
REQ-027 SHALL, with rst = 1 at a clock edge, enter EMPTY with DEC_valid = 0, DEC_instr = NOP_INSTR, DEC_pc = 0, skid invalid and overflow = 0, overriding flush and stall.
REQ-028 SHALL drive IMEM_ready = 1 in the first cycle after reset.
REQ-029 SHALL, when reset is applied mid-operation in FULL or DRAIN, discard both entries; no in-flight response is accepted during the reset cycle.

Configuration
REQ-030 SHALL honour macro FETCH_SKID_OVERFLOW_EN: when defined, overflow sets on any REQ-021 event and clears only on reset.
REQ-031 SHALL, when FETCH_SKID_OVERFLOW_EN is undefined, tie overflow to 0; the REQ-021 drop behaviour is unchanged.

Verification
REQ-032 SHALL cover streaming: no stall, IMEM_valid on 4 consecutive cycles with PC 0x0,0x4,0x8,0xC -> DEC_pc shows the same sequence, each 1 cycle later, with DEC_valid = 1 and IMEM_ready = 1 throughout.
REQ-033 SHALL cover skid: in ONE, FETCH_stall = 1 for 3 cycles while IMEM_valid arrives with PC 0x10 on the first -> FULL, IMEM_ready = 0, DEC_pc holds; after the stall is released, DEC_pc = 0x10 next cycle and state is ONE.
REQ-034 SHALL cover flush: FULL plus FETCH_flush, then IMEM_valid with PC 0x20 in the next cycle -> DEC_valid = 0 and DEC_instr = 32'h00000013 for 2 cycles, 0x20 never appears, and the state is EMPTY after DRAIN.
REQ-035 SHALL cover simultaneous events: FETCH_flush = FETCH_stall = IMEM_valid = 1 in ONE -> DRAIN and DEC_valid = 0 next cycle.
REQ-036 SHALL cover overflow: IMEM_valid in FULL -> with the macro defined overflow = 1 until rst; with it undefined overflow stays 0; in both builds DEC data is unchanged.
REQ-037 SHALL cover reset: rst asserted in FULL while a flush is active -> all outputs at reset values next cycle and IMEM_ready = 1.
